fifo_rd_stream: RTL

//  Read-side consumer for the dual-clock FIFO (standard mode, dout valid 1 cycle after rd_en).

---
 rtl/fifo_rd_stream.sv | 108 ++++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
`timescale 1ns / 1ps
// fifo_rd_stream: read-side consumer for a standard-mode dual-clock FIFO.
// It issues fifo_rd_en and captures fifo_dout on the cycle after the read.
// Captured words sit in a 3-entry skid buffer and leave as a valid/ready stream.
// Reads are credit-limited (level + inflight < 3), so the buffer cannot overflow.
// fifo_rd_en depends only on registers, fifo_empty, flush and rst_n, never on out_ready.
//
// Ports
//   rd_clk      read-domain clock, posedge
//   rst_n       asynchronous active-low reset
//   flush       synchronous discard of buffered and in-flight words
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  FIFO read strobe
//   fifo_dout   FIFO data, valid the cycle after an accepted read
//   out_valid   out_data holds a word
//   out_ready   consumer accepts the word
//   out_data    head word of the skid buffer
//   level       words held in the skid buffer (0..3)
module fifo_rd_stream #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             rd_clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);

  localparam int unsigned Slots = 3;

  logic [WIDTH-1:0] slot_q [Slots];
  logic [WIDTH-1:0] slot_d [Slots];
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [1:0]       level_q, level_d;
  logic             inflight_q, inflight_d;

  logic [2:0]       credit;
  logic             capture;
  logic             pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Outputs come straight from registers, so nothing here depends on out_ready.
  assign out_valid = (level_q != 2'd0);
  assign out_data  = slot_q[rd_ptr_q];
  assign level     = level_q;

  always_comb begin
    credit     = {1'b0, level_q} + {2'b00, inflight_q};
    // Holding rd_en low while rst_n is low keeps the FIFO idle during reset.
    fifo_rd_en = rst_n && !fifo_empty && !flush && (credit < 3'd3);
    capture    = inflight_q && !flush;
    // Flush wins over a simultaneous pop; the word is dropped with the rest.
    pop        = out_valid && out_ready && !flush;

    slot_d     = slot_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    inflight_d = fifo_rd_en;

    if (flush) begin
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
      level_d  = 2'd0;
    end else begin
      if (capture) begin
        slot_d[wr_ptr_q] = fifo_dout;
        wr_ptr_d         = next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      unique case ({capture, pop})
        2'b10:   level_d = level_q + 2'd1;
        2'b01:   level_d = level_q - 2'd1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Slots; i++) begin
        slot_q[i] <= '0;
      end
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      level_q    <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
    end
  end

endmodule
